// File: rtl/formant_smoother.sv
// formant_smoother: serial per-lane moving average over the last AVG_FRAMES formant frames (optional FORMANT_SPIKE_REJECT_EN)
module formant_smoother #(
  parameter int BIT_WIDTH    = 32,
  parameter int FORMANTS     = 5,
  parameter int AVG_FRAMES   = 4,
  parameter int SPIKE_THRESH = 1000
) (
  input  logic                                  clk_in,
  input  logic                                  rst_n_in,
  input  logic                                  formant_valid,
  input  logic [0:FORMANTS-1][BIT_WIDTH-1:0]    formant_freq,
  input  logic                                  clear_in,
  input  logic                                  out_ready,
  output logic                                  smooth_valid,
  output logic [0:FORMANTS-1][BIT_WIDTH-1:0]    smooth_freq,
  output logic [$clog2(AVG_FRAMES+1)-1:0]       frames_held,
  output logic                                  overflow_drop
);
  localparam int L  = $clog2(AVG_FRAMES);
  localparam int SW = BIT_WIDTH + L;
  localparam int HW = $clog2(AVG_FRAMES+1);
  localparam int FW = FORMANTS > 1 ? $clog2(FORMANTS) : 1;
`ifdef FORMANT_SPIKE_REJECT_EN
  localparam bit REJECT = 1'b1;
`else
  localparam bit REJECT = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;
  state_t state, state_nx;
  logic [0:FORMANTS-1][BIT_WIDTH-1:0] cap;
  logic [BIT_WIDTH-1:0] hist [AVG_FRAMES][FORMANTS];
  logic [SW-1:0] sum [FORMANTS];
  logic [L-1:0] wp;
  logic [FW-1:0] f;
  logic last, full, spike;
  logic [SW-1:0] cur_sum, new_sum;
  logic [BIT_WIDTH-1:0] old, capf, avg_old, dev, use_v, lane_out;
  // Lane datapath: running-sum update and output value for the lane selected by f
  always_comb begin
    last     = f == FW'(FORMANTS-1);
    full     = frames_held == HW'(AVG_FRAMES);
    cur_sum  = sum[f];
    old      = hist[wp][f];
    capf     = cap[f];
    avg_old  = BIT_WIDTH'(cur_sum >> L);
    dev      = capf >= avg_old ? capf - avg_old : avg_old - capf;
    spike    = REJECT && full && dev > BIT_WIDTH'(SPIKE_THRESH);
    use_v    = spike ? avg_old : capf;
    new_sum  = cur_sum - SW'(old) + SW'(use_v);
    lane_out = (full || frames_held == HW'(AVG_FRAMES-1)) ? BIT_WIDTH'(new_sum >> L) : capf;
  end
  // Next-state logic; clear forces IDLE from any state
  always_comb begin
    state_nx = state;
    state_nx = clear_in ? IDLE :
               state == IDLE  ? (formant_valid ? ACCUM : IDLE) :
               state == ACCUM ? (last ? OUTPUT : ACCUM) :
               (smooth_valid && out_ready ? IDLE : OUTPUT);
  end
  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else state <= state_nx;
  end
  // History, sums, capture, outputs and drop reporting
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cap           <= '0;
      wp            <= '0;
      f             <= '0;
      frames_held   <= '0;
      smooth_freq   <= '0;
      smooth_valid  <= 1'b0;
      overflow_drop <= 1'b0;
      for (int i = 0; i < FORMANTS; i++) sum[i] <= '0;
      for (int j = 0; j < AVG_FRAMES; j++)
        for (int i = 0; i < FORMANTS; i++) hist[j][i] <= '0;
    end else begin
      overflow_drop <= formant_valid && !clear_in && state != IDLE;
      if (clear_in) begin
        wp           <= '0;
        f            <= '0;
        frames_held  <= '0;
        smooth_valid <= 1'b0;
        for (int i = 0; i < FORMANTS; i++) sum[i] <= '0;
        for (int j = 0; j < AVG_FRAMES; j++)
          for (int i = 0; i < FORMANTS; i++) hist[j][i] <= '0;
      end else begin
        if (state == IDLE && formant_valid) begin
          cap <= formant_freq;
          f   <= '0;
        end
        if (state == ACCUM) begin
          sum[f]         <= new_sum;
          hist[wp][f]    <= use_v;
          smooth_freq[f] <= lane_out;
          f              <= f + 1'b1;
          if (last) begin
            wp          <= wp + 1'b1;
            frames_held <= full ? frames_held : frames_held + 1'b1;
          end
        end
        if (state == OUTPUT) smooth_valid <= !(smooth_valid && out_ready);
      end
    end
  end
endmodule
